// File: rtl/evm_ballot_ctrl_if.sv
// Ballot controller bus: officer/voter inputs and the clean vote/status outputs.
interface evm_ballot_ctrl_if #(
  parameter int NUM_CAND = 5,
  parameter int CNT_W    = 8
);
  logic                poll_start;
  logic                poll_end;
  logic                ballot_issue;
  logic [NUM_CAND-1:0] vote_sw;
  logic                cast_valid;
  logic [NUM_CAND-1:0] cast_sel;
  logic                ballot_led;
  logic [NUM_CAND-1:0] confirm_led;
  logic                invalid_pulse;
  logic                timeout_pulse;
  logic                poll_active;
  logic [CNT_W-1:0]    ballots_issued;
  logic [CNT_W-1:0]    votes_cast;
  logic [CNT_W-1:0]    ballots_expired;
  logic [1:0]          state;

  modport master (
    output poll_start, poll_end, ballot_issue, vote_sw,
    input  cast_valid, cast_sel, ballot_led, confirm_led, invalid_pulse,
           timeout_pulse, poll_active, ballots_issued, votes_cast,
           ballots_expired, state
  );

  modport slave (
    input  poll_start, poll_end, ballot_issue, vote_sw,
    output cast_valid, cast_sel, ballot_led, confirm_led, invalid_pulse,
           timeout_pulse, poll_active, ballots_issued, votes_cast,
           ballots_expired, state
  );
endinterface

// File: rtl/evm_ballot_ctrl.sv
// Polling-session controller: opens/closes the poll, arms one ballot per request,
// debounces candidate switches into a single one-hot cast pulse, expires idle ballots.
module evm_ballot_ctrl #(
  parameter int NUM_CAND = 5,
  parameter int DEBOUNCE = 4,
  parameter int TIMEOUT  = 1000,
  parameter int CONFIRM  = 2,
  parameter int CNT_W    = 8
) (
  input logic              clk,
  input logic              rst,
  evm_ballot_ctrl_if.slave bus
);
  localparam int DB_W = $clog2(DEBOUNCE + 1);
  localparam int TO_W = $clog2(TIMEOUT + 1);
  localparam int CF_W = $clog2(CONFIRM + 1);

  typedef enum logic [1:0] {
    CLOSED  = 2'd0,
    IDLE    = 2'd1,
    ARMED   = 2'd2,
    CONFIRM_ST = 2'd3
  } state_t;

  state_t              st;
  logic [NUM_CAND-1:0] prev_sw;
  logic [DB_W-1:0]     db_cnt;
  logic [TO_W-1:0]     to_cnt;
  logic [CF_W-1:0]     cf_cnt;
  logic                pending_close;
  logic                inv_lock;

  logic                cast_valid_q, ballot_led_q, invalid_q, timeout_q, active_q;
  logic [NUM_CAND-1:0] cast_sel_q, confirm_led_q;
  logic [CNT_W-1:0]    issued_q, cast_q, expired_q;

  logic                sw_nz, sw_onehot, db_done, to_done, cf_done, close_req;
  logic [DB_W-1:0]     db_next;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign sw_nz     = |bus.vote_sw;
  assign sw_onehot = sw_nz && ((bus.vote_sw & (bus.vote_sw - NUM_CAND'(1))) == '0);
  assign db_done   = (db_next == DB_W'(DEBOUNCE));
  assign to_done   = (to_cnt == TO_W'(TIMEOUT - 1));
  assign cf_done   = (cf_cnt == CF_W'(CONFIRM - 1));
  assign close_req = pending_close | bus.poll_end;

  // Stability count saturates at DEBOUNCE so a held invalid pattern stays "done"
  // while inv_lock suppresses repeat pulses.
  always_comb begin
    db_next = '0;
    if (!sw_nz)
      db_next = '0;
    else if (bus.vote_sw != prev_sw)
      db_next = DB_W'(1);
    else if (db_cnt == DB_W'(DEBOUNCE))
      db_next = db_cnt;
    else
      db_next = db_cnt + DB_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st            <= CLOSED;
      prev_sw       <= '0;
      db_cnt        <= '0;
      to_cnt        <= '0;
      cf_cnt        <= '0;
      pending_close <= 1'b0;
      inv_lock      <= 1'b0;
      cast_valid_q  <= 1'b0;
      cast_sel_q    <= '0;
      ballot_led_q  <= 1'b0;
      confirm_led_q <= '0;
      invalid_q     <= 1'b0;
      timeout_q     <= 1'b0;
      active_q      <= 1'b0;
      issued_q      <= '0;
      cast_q        <= '0;
      expired_q     <= '0;
    end else begin
      cast_valid_q <= 1'b0;
      cast_sel_q   <= '0;
      invalid_q    <= 1'b0;
      timeout_q    <= 1'b0;
      case (st)
        CLOSED: begin
          if (bus.poll_start) begin
            st        <= IDLE;
            active_q  <= 1'b1;
            issued_q  <= '0;
            cast_q    <= '0;
            expired_q <= '0;
          end
        end
        IDLE: begin
          if (bus.poll_end) begin
            st       <= CLOSED;
            active_q <= 1'b0;
          end else if (bus.ballot_issue) begin
            st           <= ARMED;
            ballot_led_q <= 1'b1;
            issued_q     <= sat_inc(issued_q);
            prev_sw      <= '0;
            db_cnt       <= '0;
            to_cnt       <= '0;
            inv_lock     <= 1'b0;
          end
        end
        ARMED: begin
          prev_sw <= bus.vote_sw;
          db_cnt  <= db_next;
          to_cnt  <= to_cnt + TO_W'(1);
          if (bus.poll_end) pending_close <= 1'b1;
          if (db_done && sw_onehot) begin
            st            <= CONFIRM_ST;
            cast_valid_q  <= 1'b1;
            cast_sel_q    <= bus.vote_sw;
            confirm_led_q <= bus.vote_sw;
            cast_q        <= sat_inc(cast_q);
            ballot_led_q  <= 1'b0;
            cf_cnt        <= '0;
          end else begin
            if (db_done && !inv_lock) begin
              invalid_q <= 1'b1;
              inv_lock  <= 1'b1;
            end else if (!sw_nz) begin
              inv_lock <= 1'b0;
            end
            if (to_done) begin
              timeout_q    <= 1'b1;
              expired_q    <= sat_inc(expired_q);
              ballot_led_q <= 1'b0;
              if (close_req) begin
                st            <= CLOSED;
                active_q      <= 1'b0;
                pending_close <= 1'b0;
              end else begin
                st <= IDLE;
              end
            end
          end
        end
        CONFIRM_ST: begin
          if (bus.poll_end) pending_close <= 1'b1;
          cf_cnt <= cf_cnt + CF_W'(1);
          if (cf_done) begin
            confirm_led_q <= '0;
            if (close_req) begin
              st            <= CLOSED;
              active_q      <= 1'b0;
              pending_close <= 1'b0;
            end else begin
              st <= IDLE;
            end
          end
        end
        default: st <= CLOSED;
      endcase
    end
  end

  assign bus.cast_valid      = cast_valid_q;
  assign bus.cast_sel        = cast_sel_q;
  assign bus.ballot_led      = ballot_led_q;
  assign bus.confirm_led     = confirm_led_q;
  assign bus.invalid_pulse   = invalid_q;
  assign bus.timeout_pulse   = timeout_q;
  assign bus.poll_active     = active_q;
  assign bus.ballots_issued  = issued_q;
  assign bus.votes_cast      = cast_q;
  assign bus.ballots_expired = expired_q;
  assign bus.state           = st;
endmodule

// File: doc/evm_ballot_ctrl.md
Name: evm_ballot_ctrl

Overview:
- Polling-session controller that sits in front of the vote-counting datapath.
- Opens and closes the poll, and issues one ballot per officer request.
- Debounces the voter's candidate switches and emits exactly one validated one-hot cast pulse per ballot.
- Times out abandoned ballots and keeps session statistics. The counting datapath only ever sees clean single-cycle votes.

Parameters:
- NUM_CAND, 5, number of candidate switches including NOTA (one-hot width).
- DEBOUNCE, 4, consecutive cycles a nonzero switch value must be identical before it is accepted (>=1).
- TIMEOUT, 1000, cycles a ballot may remain armed without a cast before it expires (>=2).
- CONFIRM, 2, cycles the confirmation LED is held after a cast (>=1).
- CNT_W, 8, width of session statistic counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- poll_start  in  1  single-cycle pulse: open the poll.
- poll_end  in  1  single-cycle pulse: close the poll.
- ballot_issue  in  1  single-cycle pulse from the presiding officer: issue one ballot.
- vote_sw  in  NUM_CAND  raw candidate switches, already synchronised to clk.
- cast_valid  out  1  single-cycle pulse: a vote is cast; qualifies cast_sel.
- cast_sel  out  NUM_CAND  one-hot selected candidate; 0 when cast_valid=0.
- ballot_led  out  1  high while a ballot is armed.
- confirm_led  out  NUM_CAND  one-hot LED of the last cast, held CONFIRM cycles.
- invalid_pulse  out  1  single-cycle: stable non-one-hot switch pattern rejected.
- timeout_pulse  out  1  single-cycle: armed ballot expired.
- poll_active  out  1  high when the poll is open (any state except CLOSED).
- ballots_issued  out  CNT_W  ballots issued this session.
- votes_cast  out  CNT_W  valid casts this session.
- ballots_expired  out  CNT_W  ballots that timed out this session.
- state  out  2  encoding: CLOSED=0, IDLE=1, ARMED=2, CONFIRM=3.

Behaviour:
- Reset: state=CLOSED; every output 0; debounce, timeout and confirm counters cleared; pending_close=0.
- All outputs are registered. cast_valid, invalid_pulse and timeout_pulse are each high for exactly one cycle.
- CLOSED:
  - poll_start moves to IDLE and clears all three statistic counters in the same edge.
  - poll_end, ballot_issue and vote_sw are ignored.
- IDLE:
  - poll_end moves to CLOSED.
  - Otherwise ballot_issue moves to ARMED, increments ballots_issued, and clears the debounce and timeout counters.
  - If poll_end and ballot_issue arrive in the same cycle, poll_end wins and no ballot is issued.
  - poll_start is ignored.
- ARMED:
  - ballot_led=1; ballot_issue and poll_start are ignored.
  - Debounce: sample vote_sw every cycle. The stability counter increments while the value is nonzero and equal to the previous sample. It restarts on any change or on zero.
  - When a value has been identical and nonzero for DEBOUNCE consecutive cycles:
    - If it is one-hot: on the next edge cast_valid=1, cast_sel=value, confirm_led=value, votes_cast increments, and state moves to CONFIRM.
    - If it is not one-hot: invalid_pulse fires once and state stays ARMED. No further invalid_pulse fires until vote_sw returns to 0. The timeout keeps running.
  - Timeout counter increments each ARMED cycle. When it reaches TIMEOUT: timeout_pulse fires, ballots_expired increments, state moves to IDLE (or CLOSED if pending_close is set), and ballot_led drops.
  - If cast acceptance and timeout occur in the same cycle, the cast wins and no timeout is recorded.
  - poll_end in ARMED sets pending_close; the ballot still completes.
- CONFIRM:
  - confirm_led is held for CONFIRM cycles, then cleared.
  - Exit goes to IDLE, or to CLOSED if pending_close is set (pending_close is then cleared).
  - poll_end here also sets pending_close.
  - ballot_issue is ignored.
- Counters saturate at 2^CNT_W-1; there is no wrap-around.
- A held switch never produces a second cast: a new cast requires a fresh ballot_issue, and a value already stable at ARMED entry must still meet the full DEBOUNCE count from entry.
- rst asserted in any state, including mid-debounce or mid-confirm, returns to the reset condition on the next edge. No cast_valid is emitted in that edge.

Test Plan (DEBOUNCE=4, TIMEOUT=20, CONFIRM=2, CNT_W=8):
- poll_start, ballot_issue, vote_sw=00100 held 4 cycles → exactly one cast_valid with cast_sel=00100; confirm_led=00100 for 2 cycles; votes_cast=1, ballots_issued=1; return to IDLE.
- Armed ballot, vote_sw toggling 00010/00000 every 2 cycles (bounce), then stable 00010 → no cast during bounce; single cast after 4 stable cycles.
- Armed ballot, vote_sw=00011 stable 10 cycles → one invalid_pulse only; vote_sw=0 then 01000 stable → cast 01000.
- Armed ballot, no input → timeout_pulse on cycle 20; ballots_expired=1; state=IDLE; a subsequent held vote_sw=00001 produces no cast.
- poll_end during ARMED, then valid vote → cast occurs, CONFIRM runs, then state=CLOSED and poll_active=0; ballot_issue afterwards is ignored.
- ballots_issued at 255 plus another ballot → stays 255; rst mid-debounce → all outputs 0, state=CLOSED, no cast_valid.
